// File: rtl/decode_pkg.sv
// Shared types and constants for the decode scheduler.
package decode_pkg;

    // Job FSM encoding (3 bits).
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClr   = 3'd1,
        StStart = 3'd2,
        StRun   = 3'd3,
        StFin   = 3'd4
    } state_e;

    // Job result codes reported on status alongside doneN.
    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_OVF = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;

endpackage

// File: rtl/decode_rr_arb.sv
// Two-way round-robin arbiter: the channel not granted last wins a tie.
module decode_rr_arb (
    input  logic [1:0] req_i,
    input  logic       ptr_i,      // index of the last granted channel
    output logic       gnt_idx_o,
    output logic       gnt_vld_o
);

    // Single requester wins outright; on a tie the pointer is inverted.
    always_comb begin
        gnt_vld_o = |req_i;
        if (&req_i) begin
            gnt_idx_o = ~ptr_i;
        end else begin
            gnt_idx_o = req_i[1];
        end
    end

endmodule

// File: rtl/decode_sched.sv
// Two-channel decoder job scheduler: arbitrates requests, sequences the decoder
// through clear/start, counts output bytes and ends each job with a status.
module decode_sched
    import decode_pkg::*;
#(
    parameter int unsigned LEN_W = 16,
    parameter int unsigned TMO   = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic             sel,
    output logic             busy,
    output logic             dec_clr,
    output logic             dec_ce,
    input  logic             dec_valid,
    input  logic             dec_done,
    output logic             done0,
    output logic             done1,
    output logic [1:0]       status,
    output logic [LEN_W-1:0] byte_cnt
);

    // Idle counter only has to reach TMO-1.
    localparam int unsigned   IdleW   = (TMO > 2) ? $clog2(TMO) : 1;
    localparam logic [IdleW-1:0] IdleMax = IdleW'(TMO - 1);
    localparam logic [LEN_W-1:0] CntMax  = '1;

    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    logic             ptr_q, ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic             busy_q, busy_d;
    logic             clr_q, clr_d;
    logic             ce_q, ce_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic [1:0]       status_q, status_d;

    logic             gnt_idx;
    logic             gnt_vld;
    logic [LEN_W-1:0] cnt_inc;

    decode_rr_arb u_arb (
        .req_i     ({req1, req0}),
        .ptr_i     (ptr_q),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    // Byte counter saturates rather than wrapping.
    assign cnt_inc = (cnt_q != CntMax) ? cnt_q + LEN_W'(1) : cnt_q;

    // Next-state, counters and registered-output next values.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        idle_d   = idle_q;
        status_d = status_q;

        unique case (state_q)
            StIdle: begin
                if (gnt_vld) begin
                    sel_d   = gnt_idx;
                    len_d   = gnt_idx ? len1 : len0;
                    cnt_d   = '0;
                    idle_d  = '0;
                    state_d = StClr;
                end
            end
            StClr:   state_d = StStart;
            StStart: state_d = StRun;
            StRun: begin
                if (dec_done) begin
                    // A byte arriving with the end marker still counts.
                    if (dec_valid) cnt_d = cnt_inc;
                    status_d = ST_OK;
                    state_d  = StFin;
                end else if (dec_valid && (len_q != '0) && (cnt_q == len_q)) begin
                    // The overflowing byte is dropped; len of 0 means no limit.
                    status_d = ST_OVF;
                    state_d  = StFin;
                end else if (dec_valid) begin
                    cnt_d  = cnt_inc;
                    idle_d = '0;
                end else if (idle_q == IdleMax) begin
                    status_d = ST_TMO;
                    state_d  = StFin;
                end else begin
                    idle_d = idle_q + IdleW'(1);
                end
            end
            StFin: begin
                ptr_d   = sel_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so derive them from the state being entered.
        busy_d  = (state_d != StIdle);
        clr_d   = (state_d == StClr);
        ce_d    = (state_d == StStart);
        done0_d = (state_d == StFin) && !sel_d;
        done1_d = (state_d == StFin) && sel_d;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            sel_q    <= 1'b0;
            ptr_q    <= 1'b0;
            len_q    <= '0;
            cnt_q    <= '0;
            idle_q   <= '0;
            busy_q   <= 1'b0;
            clr_q    <= 1'b0;
            ce_q     <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
            busy_q   <= busy_d;
            clr_q    <= clr_d;
            ce_q     <= ce_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            status_q <= status_d;
        end
    end

    assign sel      = sel_q;
    assign busy     = busy_q;
    assign dec_clr  = clr_q;
    assign dec_ce   = ce_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign status   = status_q;
    assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_decode_sched.sv
// Directed testbench for decode_sched.
module tb_decode_sched;

    localparam int unsigned LW = 16;
    localparam int unsigned TM = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [LW-1:0] len0 = '0;
    logic [LW-1:0] len1 = '0;
    logic          dec_valid = 1'b0;
    logic          dec_done = 1'b0;
    logic          sel, busy, dec_clr, dec_ce, done0, done1;
    logic [1:0]    status;
    logic [LW-1:0] byte_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_sched #(
        .LEN_W (LW),
        .TMO   (TM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .len0      (len0),
        .len1      (len1),
        .sel       (sel),
        .busy      (busy),
        .dec_clr   (dec_clr),
        .dec_ce    (dec_ce),
        .dec_valid (dec_valid),
        .dec_done  (dec_done),
        .done0     (done0),
        .done1     (done1),
        .status    (status),
        .byte_cnt  (byte_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        tick();
        tick();
        n_cmp++; if ({sel, busy, dec_clr, dec_ce, done0, done1} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctl: got %b want 000000",
                              {sel, busy, dec_clr, dec_ce, done0, done1}); end
        n_cmp++; if ({status, byte_cnt} !== 18'd0) begin
            n_err++; $display("FAIL reset_stat: got %0d/%0d want 0/0", status, byte_cnt); end
        rst = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_job();
        len0 = 16'd10;
        req0 = 1'b1;
        tick();
        n_cmp++; if ({dec_clr, dec_ce, busy, sel} !== 4'b1010) begin
            n_err++; $display("FAIL single_clr: got clr/ce/busy/sel=%b want 1010",
                              {dec_clr, dec_ce, busy, sel}); end
        tick();
        n_cmp++; if ({dec_clr, dec_ce} !== 2'b01) begin
            n_err++; $display("FAIL single_ce: got clr/ce=%b want 01", {dec_clr, dec_ce}); end
        tick();
        n_cmp++; if (dec_ce !== 1'b0) begin
            n_err++; $display("FAIL single_ce_pulse: got %b want 0", dec_ce); end
        dec_valid = 1'b1;
        repeat (5) tick();
        dec_valid = 1'b0;
        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;
        req0 = 1'b0;
        n_cmp++; if ({done0, done1} !== 2'b10) begin
            n_err++; $display("FAIL single_done: got done0/1=%b want 10", {done0, done1}); end
        n_cmp++; if (status !== 2'b00) begin
            n_err++; $display("FAIL single_status: got %b want 00", status); end
        n_cmp++; if (byte_cnt !== 16'd5) begin
            n_err++; $display("FAIL single_cnt: got %0d want 5", byte_cnt); end
        tick();
        n_cmp++; if ({done0, busy, byte_cnt} !== {2'b00, 16'd5}) begin
            n_err++; $display("FAIL single_after: got done0=%b busy=%b cnt=%0d want 0 0 5",
                              done0, busy, byte_cnt); end
    endtask

    task automatic test_contention();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        len0 = '0;
        len1 = '0;
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        n_cmp++; if ({sel, dec_clr} !== 2'b11) begin
            n_err++; $display("FAIL cont_first: got sel/clr=%b want 11", {sel, dec_clr}); end
        tick();
        tick();
        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;
        req1 = 1'b0;
        n_cmp++; if ({done0, done1} !== 2'b01) begin
            n_err++; $display("FAIL cont_done1: got done0/1=%b want 01", {done0, done1}); end
        tick();
        n_cmp++; if ({busy, dec_clr} !== 2'b00) begin
            n_err++; $display("FAIL cont_gap: got busy/clr=%b want 00", {busy, dec_clr}); end
        tick();
        n_cmp++; if ({sel, dec_clr} !== 2'b01) begin
            n_err++; $display("FAIL cont_second: got sel/clr=%b want 01", {sel, dec_clr}); end
        tick();
        tick();
        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;
        req0 = 1'b0;
        n_cmp++; if ({done0, done1} !== 2'b10) begin
            n_err++; $display("FAIL cont_done0: got done0/1=%b want 10", {done0, done1}); end
        tick();
    endtask

    task automatic test_overflow();
        len1 = 16'd3;
        req1 = 1'b1;
        tick();
        tick();
        req1 = 1'b0;  // dropped mid-job; job must continue
        tick();
        dec_valid = 1'b1;
        repeat (3) tick();
        n_cmp++; if ({done1, byte_cnt} !== {1'b0, 16'd3}) begin
            n_err++; $display("FAIL ovf_pre: got done1=%b cnt=%0d want 0 3", done1, byte_cnt); end
        tick();
        dec_valid = 1'b0;
        n_cmp++; if ({done1, status} !== 3'b101) begin
            n_err++; $display("FAIL ovf_done: got done1=%b status=%b want 1 01", done1, status); end
        n_cmp++; if (byte_cnt !== 16'd3) begin
            n_err++; $display("FAIL ovf_cnt: got %0d want 3", byte_cnt); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin
            n_err++; $display("FAIL ovf_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_timeout();
        logic early;
        early = 1'b0;
        len0 = 16'd5;
        req0 = 1'b1;
        tick();
        tick();
        req0 = 1'b0;
        n_cmp++; if (dec_ce !== 1'b1) begin
            n_err++; $display("FAIL tmo_start: got dec_ce=%b want 1", dec_ce); end
        // Eight RUN cycles with no done, then FIN.
        repeat (TM) begin
            tick();
            if (done0 || done1) early = 1'b1;
        end
        n_cmp++; if (early !== 1'b0) begin
            n_err++; $display("FAIL tmo_early: got early done=%b want 0", early); end
        tick();
        n_cmp++; if ({done0, status} !== 3'b110) begin
            n_err++; $display("FAIL tmo_done: got done0=%b status=%b want 1 10", done0, status); end
        n_cmp++; if (byte_cnt !== 16'd0) begin
            n_err++; $display("FAIL tmo_cnt: got %0d want 0", byte_cnt); end
        tick();
    endtask

    task automatic test_back_to_back();
        len0 = 16'd10;
        req0 = 1'b1;
        tick();
        tick();
        tick();
        dec_valid = 1'b1;
        repeat (9) tick();
        dec_done = 1'b1;  // tenth byte arrives with the end marker
        tick();
        dec_valid = 1'b0;
        dec_done = 1'b0;
        n_cmp++; if ({done0, status} !== 3'b100) begin
            n_err++; $display("FAIL coinc_done: got done0=%b status=%b want 1 00", done0, status); end
        n_cmp++; if (byte_cnt !== 16'd10) begin
            n_err++; $display("FAIL coinc_cnt: got %0d want 10", byte_cnt); end
        // req0 still held: exactly one IDLE cycle, then a new job.
        tick();
        n_cmp++; if ({busy, dec_clr} !== 2'b00) begin
            n_err++; $display("FAIL b2b_gap: got busy/clr=%b want 00", {busy, dec_clr}); end
        tick();
        n_cmp++; if ({dec_clr, sel, byte_cnt} !== {2'b10, 16'd0}) begin
            n_err++; $display("FAIL b2b_regrant: got clr=%b sel=%b cnt=%0d want 1 0 0",
                              dec_clr, sel, byte_cnt); end
        req0 = 1'b0;
        tick();
        tick();
        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;
        n_cmp++; if (done0 !== 1'b1) begin
            n_err++; $display("FAIL b2b_done: got done0=%b want 1", done0); end
        tick();
    endtask

    task automatic test_no_limit();
        logic early;
        early = 1'b0;
        len1 = '0;
        req1 = 1'b1;
        tick();
        tick();
        tick();
        req1 = 1'b0;
        dec_valid = 1'b1;
        repeat (300) begin
            tick();
            if (done0 || done1) early = 1'b1;
        end
        dec_valid = 1'b0;
        n_cmp++; if (early !== 1'b0) begin
            n_err++; $display("FAIL nolim_early: got early done=%b want 0", early); end
        n_cmp++; if (byte_cnt !== 16'd300) begin
            n_err++; $display("FAIL nolim_cnt: got %0d want 300", byte_cnt); end
        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;
        n_cmp++; if ({done1, status} !== 3'b100) begin
            n_err++; $display("FAIL nolim_done: got done1=%b status=%b want 1 00", done1, status); end
        tick();
    endtask

    task automatic test_reset_mid_job();
        logic seen;
        seen = 1'b0;
        len0 = '0;
        req0 = 1'b1;
        tick();
        tick();
        tick();
        dec_valid = 1'b1;
        repeat (3) tick();
        dec_valid = 1'b0;
        n_cmp++; if ({busy, byte_cnt} !== {1'b1, 16'd3}) begin
            n_err++; $display("FAIL rstm_pre: got busy=%b cnt=%0d want 1 3", busy, byte_cnt); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if ({sel, busy, dec_clr, dec_ce, done0, done1, status, byte_cnt} !== 24'd0) begin
            n_err++; $display("FAIL rstm_async: got %h want 0",
                              {sel, busy, dec_clr, dec_ce, done0, done1, status, byte_cnt}); end
        repeat (2) begin
            tick();
            if (done0 || done1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin
            n_err++; $display("FAIL rstm_nodone: got done seen=%b want 0", seen); end
        rst = 1'b0;
        tick();
        n_cmp++; if ({dec_clr, sel, busy} !== 3'b101) begin
            n_err++; $display("FAIL rstm_regrant: got clr/sel/busy=%b want 101",
                              {dec_clr, sel, busy}); end
        tick();
        tick();
        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;
        req0 = 1'b0;
        n_cmp++; if ({done0, byte_cnt} !== {1'b1, 16'd0}) begin
            n_err++; $display("FAIL rstm_done: got done0=%b cnt=%0d want 1 0", done0, byte_cnt); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_contention();
        test_overflow();
        test_timeout();
        test_back_to_back();
        test_no_limit();
        test_reset_mid_job();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_sched.md
DECODE_SCHED -- requirements
Module: decode_sched

Interface
REQ-001 Parameter LEN_W, default 16, SHALL set the width of the job length and byte counters.
REQ-002 Parameter TMO, default 16'hFFFF, SHALL set the number of consecutive cycles without dec_valid that cause a job abort.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 req0, req1  input  1 each  SHALL be the job requests from channels 0 and 1, level-held until done.
REQ-006 len0, len1  input  LEN_W each  SHALL give the maximum output bytes for each channel's job; they SHALL be sampled at grant.
REQ-007 sel  output  1  SHALL select the channel whose stream is muxed into the decoder.
REQ-008 busy  output  1  SHALL be high while a job is owned by a channel.
REQ-009 dec_clr  output  1  SHALL be a one-cycle pulse that clears the decoder and its history.
REQ-010 dec_ce  output  1  SHALL be a one-cycle start pulse to the decoder.
REQ-011 dec_valid  input  1  SHALL be the decoder's output byte strobe.
REQ-012 dec_done  input  1  SHALL be the decoder's end-marker level.
REQ-013 done0, done1  output  1 each  SHALL pulse for one cycle at job completion.
REQ-014 status  output  2  SHALL give the job result, valid with doneN: 00 OK, 01 overflow, 10 timeout.
REQ-015 byte_cnt  output  LEN_W  SHALL count bytes produced by the current or last job.

Function
REQ-016 The FSM SHALL have the states IDLE, CLR, START, RUN and FIN.
REQ-017 IDLE: on any request, the FSM SHALL grant round-robin (pointer = last granted channel; the other channel wins ties), latch sel and len, clear byte_cnt and the idle counter, and go to CLR.
REQ-018 CLR: dec_clr=1 for exactly one cycle, then the FSM SHALL go to START.
REQ-019 START: dec_ce=1 for exactly one cycle, then the FSM SHALL go to RUN.
REQ-020 RUN: each dec_valid SHALL increment byte_cnt, and the idle counter SHALL reset to 0 on dec_valid and otherwise increment.
REQ-021 RUN exit priority: dec_done SHALL give OK, then byte_cnt reaching latched len with another dec_valid SHALL give overflow, then idle counter == TMO-1 SHALL give timeout; every exit SHALL go to FIN.
REQ-022 A dec_valid coinciding with dec_done SHALL still be counted.
REQ-023 FIN: doneN (N=sel) SHALL pulse with status set, the round-robin pointer SHALL update to sel, then the FSM SHALL return to IDLE; the overflowing byte SHALL NOT be counted.
REQ-024 len=0 SHALL behave as "no limit" and SHALL NOT generate overflow.
REQ-025 byte_cnt SHALL saturate at all-ones and SHALL NOT wrap.
REQ-026 A request drop mid-job SHALL be ignored; the job SHALL run to FIN.
REQ-027 A request still high after its doneN SHALL be treated as a new job.
REQ-028 busy SHALL be high in CLR, START, RUN and FIN, and low in IDLE.
REQ-029 Latency from request rising in IDLE: dec_clr SHALL assert at cycle +1 and dec_ce at cycle +2.
REQ-030 Back-to-back jobs SHALL have exactly one IDLE cycle between FIN and CLR.

Reset
REQ-031 On rst, the FSM SHALL go to IDLE.
REQ-032 On rst, sel, busy, dec_clr, dec_ce, done0, done1, status, byte_cnt, the idle counter and the RR pointer SHALL all be 0 (pointer 0 means channel 1 wins the first tie).
REQ-033 Reset mid-job SHALL abort the job without a doneN pulse.

Structure
REQ-034 Package decode_pkg SHALL hold the FSM state encoding (3 bits) and the status codes ST_OK, ST_OVF and ST_TMO.
REQ-035 Sub-module decode_rr_arb SHALL implement the 2-way round-robin arbiter (req[1:0], pointer → grant index, grant valid); the FSM, counters and length compare SHALL be top-level.

Verification
REQ-036 Single job: req0=1, len0=10, 5 dec_valid then dec_done -> dec_clr at +1, dec_ce at +2, done0 pulse, status=00, byte_cnt=5.
REQ-037 Contention: req0=req1=1 from reset -> channel 1 served first, then channel 0, one IDLE cycle between jobs, with sel following the grant.
REQ-038 Overflow: len1=3, 4 dec_valid without dec_done -> done1 with status=01, byte_cnt=3.
REQ-039 Timeout: TMO=8, no dec_valid after dec_ce -> done with status=10 exactly 8 RUN cycles after START.
REQ-040 Corners: dec_valid coincident with dec_done on byte 10 of len=10 -> status=00, byte_cnt=10; len=0 with 300 bytes -> no overflow.
REQ-041 rst asserted in RUN -> all outputs 0 asynchronously, no doneN pulse, and the next request is granted normally.
